dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the MEM stage and the off-chip data memory.
- Generates `mem_stall_o`, which drives the pipeline-register stall inputs (`mem_stall_i`, including MEM/WB), for as long as a request cannot complete.
- Answers MEM-stage loads/stores on a hit; runs writeback/refill transactions to memory on a miss.

---
 rtl/dcache_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller placed between
// the MEM stage and off-chip data memory; stalls the pipeline while a miss is serviced.
module dcache_ctrl #(
  parameter int INDEX_W     = 5,
  parameter int MEM_LAT_MAX = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         mem_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i,
  output logic         err_o
);

  localparam int NUM_LINES = 1 << INDEX_W;
  localparam int TAG_W     = 32 - 5 - INDEX_W;
  localparam int WD_W      = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_e;

  state_e               state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];

  logic [TAG_W-1:0]     missTag_q;
  logic [INDEX_W-1:0]   missIdx_q;
  logic                 memReq_q;
  logic                 memWe_q;
  logic [31:0]          memAddr_q;
  logic [255:0]         memWdata_q;
  logic [WD_W-1:0]      wdCnt_q;
  logic                 err_q;

  logic [2:0]           cpuOff;
  logic [INDEX_W-1:0]   cpuIdx;
  logic [TAG_W-1:0]     cpuTag;
  logic [1:0]           unusedAddrBits;
  logic [255:0]         lineRd;
  logic                 isIdle;
  logic                 hit;
  logic                 ackSeen;
  logic                 storeHit;
  logic                 missDetect;
  logic                 wbDone;
  logic                 refillDone;

  assign cpuOff         = cpu_addr_i[4:2];
  assign cpuIdx         = cpu_addr_i[4+INDEX_W:5];
  assign cpuTag         = cpu_addr_i[31:5+INDEX_W];
  assign unusedAddrBits = cpu_addr_i[1:0];

  assign isIdle     = (state_q == IDLE);
  assign hit        = cpu_req_i & valid_q[cpuIdx] & (tag_q[cpuIdx] == cpuTag);
  assign ackSeen    = memReq_q & mem_ack_i;
  assign storeHit   = isIdle & hit & cpu_we_i;
  assign missDetect = isIdle & cpu_req_i & ~hit;
  assign wbDone     = (state_q == WRITEBACK) & ackSeen;
  assign refillDone = (state_q == REFILL) & ackSeen;

  // Invalid lines read as zero so the load port never shows uninitialised array contents.
  assign lineRd      = data_q[cpuIdx];
  assign cpu_rdata_o = valid_q[cpuIdx] ? lineRd[{cpuOff, 5'b0} +: 32] : 32'h0;
  assign mem_stall_o = rst_n & (isIdle ? (cpu_req_i & ~hit) : 1'b1);

  assign mem_req_o   = memReq_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign err_o       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (storeHit) begin
      dirty_q[cpuIdx] <= 1'b1;
    end else if (wbDone) begin
      dirty_q[missIdx_q] <= 1'b0;
    end else if (refillDone) begin
      valid_q[missIdx_q] <= 1'b1;
      dirty_q[missIdx_q] <= 1'b0;
    end
  end

  // Line storage carries no reset; valid_q guards every use of it.
  always_ff @(posedge clk) begin
    if (storeHit) begin
      data_q[cpuIdx][{cpuOff, 5'b0} +: 32] <= cpu_wdata_i;
    end else if (refillDone) begin
      data_q[missIdx_q] <= mem_rdata_i;
      tag_q[missIdx_q]  <= missTag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      missTag_q  <= '0;
      missIdx_q  <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (missDetect) begin
            missTag_q <= cpuTag;
            missIdx_q <= cpuIdx;
            memReq_q  <= 1'b1;
            if (valid_q[cpuIdx] & dirty_q[cpuIdx]) begin
              state_q    <= WRITEBACK;
              memWe_q    <= 1'b1;
              memAddr_q  <= {tag_q[cpuIdx], cpuIdx, 5'b0};
              memWdata_q <= data_q[cpuIdx];
            end else begin
              state_q   <= REFILL;
              memWe_q   <= 1'b0;
              memAddr_q <= {cpuTag, cpuIdx, 5'b0};
            end
          end
        end
        // Dropping the request on ack leaves a one-cycle gap before the refill request.
        WRITEBACK: begin
          if (ackSeen) begin
            state_q  <= REFILL;
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
          end
        end
        REFILL: begin
          if (!memReq_q) begin
            memReq_q  <= 1'b1;
            memWe_q   <= 1'b0;
            memAddr_q <= {missTag_q, missIdx_q, 5'b0};
          end else if (mem_ack_i) begin
            memReq_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
          memWe_q  <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog only flags a slow memory; the controller keeps waiting for the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdCnt_q <= '0;
      err_q   <= 1'b0;
    end else if (memReq_q & ~mem_ack_i) begin
      if (wdCnt_q != WD_W'(MEM_LAT_MAX)) begin
        wdCnt_q <= wdCnt_q + 1'b1;
      end
      if (wdCnt_q == WD_W'(MEM_LAT_MAX - 1)) begin
        err_q <= 1'b1;
      end
    end else begin
      wdCnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: directed scenarios plus random accesses checked
// against a flat-memory reference and a tag-occupancy model.
module tb_dcache_ctrl;

  localparam int INDEX_W     = 5;
  localparam int MEM_LAT_MAX = 1023;
  localparam int NL          = 1 << INDEX_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         mem_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;
  logic         err_o;

  dcache_ctrl #(.INDEX_W(INDEX_W), .MEM_LAT_MAX(MEM_LAT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .mem_stall_o(mem_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;

  // Off-chip memory contents and the program-order view of memory, both by word address.
  logic [31:0] backing [logic [29:0]];
  logic [31:0] golden  [logic [29:0]];

  bit          mValid [NL];
  bit          mDirty [NL];
  logic [21:0] mTag   [NL];

  int           memLat  = 1;
  bit           ackHold = 1'b0;
  int           wbCount = 0;
  int           rfCount = 0;
  logic [31:0]  lastWbAddr = '0;
  logic [31:0]  lastRfAddr = '0;
  logic [255:0] lastWbData = '0;
  logic [31:0]  readData;
  int           stallCycles;

  function automatic logic [31:0] initWord(logic [29:0] wa);
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  function automatic logic [31:0] memWord(logic [29:0] wa);
    if (backing.exists(wa)) return backing[wa];
    return initWord(wa);
  endfunction

  function automatic logic [31:0] goldWord(logic [29:0] wa);
    if (golden.exists(wa)) return golden[wa];
    return initWord(wa);
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < NL; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
      mTag[i]   = '0;
    end
    golden = backing;
  endtask

  // Memory responder: acks after memLat request cycles, serving and absorbing whole lines.
  initial begin
    int waitCnt;
    logic [29:0] base;
    waitCnt     = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (!rst_n || !mem_req_o) begin
        waitCnt = 0;
      end else if (!ackHold) begin
        waitCnt++;
        if (waitCnt >= memLat) begin
          waitCnt   = 0;
          mem_ack_i = 1'b1;
          base      = mem_addr_o[31:2];
          if (mem_we_o) begin
            for (int w = 0; w < 8; w++) backing[base + 30'(w)] = mem_wdata_o[w*32 +: 32];
            wbCount++;
            lastWbAddr = mem_addr_o;
            lastWbData = mem_wdata_o;
          end else begin
            for (int w = 0; w < 8; w++) mem_rdata_i[w*32 +: 32] = memWord(base + 30'(w));
            rfCount++;
            lastRfAddr = mem_addr_o;
          end
        end
      end
    end
  end

  // One CPU access held until the stall drops, then checked against the reference.
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [21:0]  t;
    logic [4:0]   idx;
    bit           expHit;
    bit           expWb;
    int           expStall;
    logic [31:0]  expWbAddr;
    logic [255:0] expWbData;
    int           wb0;
    int           rf0;
    t         = addr[31:10];
    idx       = addr[9:5];
    expHit    = mValid[idx] && (mTag[idx] == t);
    expWb     = !expHit && mValid[idx] && mDirty[idx];
    expStall  = expHit ? 0 : (expWb ? 2 * memLat + 2 : memLat + 1);
    expWbAddr = {mTag[idx], idx, 5'b0};
    for (int w = 0; w < 8; w++) expWbData[w*32 +: 32] = goldWord(expWbAddr[31:2] + 30'(w));
    wb0 = wbCount;
    rf0 = rfCount;

    @(negedge clk);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    #1;
    stallCycles = 0;
    while (mem_stall_o && stallCycles < 3000) begin
      @(negedge clk);
      #1;
      stallCycles++;
    end
    readData = cpu_rdata_o;

    checkOutput("stallCycles", 256'(stallCycles), 256'(expStall));
    checkOutput("writebackCount", 256'(wbCount - wb0), 256'(expWb));
    checkOutput("refillCount", 256'(rfCount - rf0), expHit ? 256'd0 : 256'd1);
    if (expWb) begin
      checkOutput("writebackAddr", 256'(lastWbAddr), 256'(expWbAddr));
      checkOutput("writebackData", lastWbData, expWbData);
    end
    if (!expHit) checkOutput("refillAddr", 256'(lastRfAddr), 256'({t, idx, 5'b0}));
    if (!we) checkOutput("loadData", 256'(readData), 256'(goldWord(addr[31:2])));

    if (!expHit) begin
      mValid[idx] = 1'b1;
      mDirty[idx] = 1'b0;
      mTag[idx]   = t;
    end
    if (we) begin
      mDirty[idx]         = 1'b1;
      golden[addr[31:2]] = wdata;
    end
  endtask

  initial begin
    logic [21:0] tagSel;
    logic [31:0] rAddr;
    rst_n       = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    backing[30'h10] = 32'h1111_1111;
    clearModel();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("resetMemReq", 256'(mem_req_o), 256'd0);
    checkOutput("resetMemWe", 256'(mem_we_o), 256'd0);
    checkOutput("resetStall", 256'(mem_stall_o), 256'd0);
    checkOutput("resetErr", 256'(err_o), 256'd0);
    checkOutput("resetMemAddr", 256'(mem_addr_o), 256'd0);
    checkOutput("resetRdata", 256'(cpu_rdata_o), 256'd0);

    memLat = 3;
    applyStimulus(1'b0, 32'h0000_0040, '0);
    checkOutput("firstLoadWord0", 256'(readData), 256'h1111_1111);
    applyStimulus(1'b0, 32'h0000_0044, '0);
    checkOutput("hitNoMemReq", 256'(mem_req_o), 256'd0);
    applyStimulus(1'b1, 32'h0000_0048, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_0048, '0);
    checkOutput("storeThenLoad", 256'(readData), 256'hDEAD_BEEF);

    memLat = 2;
    applyStimulus(1'b0, 32'h0000_0440, '0);
    checkOutput("conflictWbAddr", 256'(lastWbAddr), 256'h40);
    checkOutput("conflictWbWord2", 256'(lastWbData[95:64]), 256'hDEAD_BEEF);

    applyStimulus(1'b1, 32'h0000_0080, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h0000_0080, '0);
    applyStimulus(1'b0, 32'h0000_0480, '0);
    checkOutput("storeMissDirtyWord", 256'(lastWbData[31:0]), 256'hCAFE_F00D);

    memLat = 4;
    @(negedge clk);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_00C0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reqBeforeReset", 256'(mem_req_o), 256'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reqDuringReset", 256'(mem_req_o), 256'd0);
    checkOutput("stallDuringReset", 256'(mem_stall_o), 256'd0);
    checkOutput("addrDuringReset", 256'(mem_addr_o), 256'd0);
    cpu_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    memLat = 3;
    applyStimulus(1'b0, 32'h0000_0040, '0);

    ackHold = 1'b1;
    @(negedge clk);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0100;
    repeat (1000) @(negedge clk);
    #1;
    checkOutput("errBeforeLimit", 256'(err_o), 256'd0);
    checkOutput("stallWhileWaiting", 256'(mem_stall_o), 256'd1);
    repeat (40) @(negedge clk);
    #1;
    checkOutput("errAtLimit", 256'(err_o), 256'd1);
    ackHold = 1'b0;
    stallCycles = 0;
    while (mem_stall_o && stallCycles < 20) begin
      @(negedge clk);
      #1;
      stallCycles++;
    end
    checkOutput("watchdogCompletes", 256'(mem_stall_o), 256'd0);
    checkOutput("watchdogLoadData", 256'(cpu_rdata_o), 256'(goldWord(30'h40)));
    checkOutput("errSticky", 256'(err_o), 256'd1);
    @(negedge clk);
    cpu_req_i = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("errClearedByReset", 256'(err_o), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();

    for (int i = 0; i < 80; i++) begin
      memLat = $urandom_range(1, 4);
      case ($urandom_range(0, 2))
        0:       tagSel = 22'h000000;
        1:       tagSel = 22'h000001;
        default: tagSel = 22'h3FFFFF;
      endcase
      rAddr = {tagSel, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      applyStimulus(1'($urandom_range(0, 1)), rAddr, $urandom);
    end

    @(negedge clk);
    cpu_req_i = 1'b0;
    #1;
    checkOutput("finalErr", 256'(err_o), 256'd0);
    checkOutput("finalMemReq", 256'(mem_req_o), 256'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
